tspcff_timing_board: RTL and testbench



---
 rtl/tspcff_board_pkg.sv | 81 ++++++++
 rtl/tspcff_delay_model.sv | 36 +++
 rtl/tspcff_timing_board.sv | 153 +++++++++++++++
 tb/tb_tspcff_timing_board.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tspcff_board_pkg.sv
`timescale 1ns/100fs
// -----------------------------------------------------------------------------
// tspcff_board_pkg
//
// Shared constants and helpers for the TSPC flip-flop characterisation board.
//
// Contents:
//   * Default delay-model coefficients (intrinsic delay, slope factor, drive
//     resistance, upper clamp) in SI units.
//   * Characterisation grids: 7 clock-slope points (ns) and 7 load points (fF),
//     exposed through index functions so benches can sweep them.
//   * Small real-valued helpers: input sanitising, clamping, and conversion
//     from seconds to simulator time units (the time unit is 1 ns).
// -----------------------------------------------------------------------------
package tspcff_board_pkg;

    // Delay-model defaults (SI units)
    localparam real T_INTRINSIC_DEF = 40.0e-12;  // s, clk-to-q at zero slope/load
    localparam real K_SLOPE_DEF     = 0.25;      // s of delay per s of clk slope
    localparam real R_DRIVE_DEF     = 5.0e3;     // ohm
    localparam real T_MAX_DEF       = 5.0e-9;    // s, clamp on computed delay

    // Seconds represented by one unit of delay in this time base
    localparam real S_PER_TICK = 1.0e-9;

    // Number of points in each characterisation grid
    localparam int GRID_POINTS = 7;

    // Characterisation grid: clock/data slopes in ns. Out-of-range indices
    // saturate to the nearest end of the grid.
    function automatic real slope_grid_ns(input int idx);
        real v;
        case (idx)
            0:       v = 0.001;
            1:       v = 0.03;
            2:       v = 0.07;
            3:       v = 0.10;
            4:       v = 0.13;
            5:       v = 0.17;
            default: v = (idx < 0) ? 0.001 : 0.20;
        endcase
        return v;
    endfunction

    // Characterisation grid: output loads in fF, saturating like the slopes.
    function automatic real load_grid_ff(input int idx);
        real v;
        case (idx)
            0:       v = 0.02;
            1:       v = 1.25;
            2:       v = 2.5;
            3:       v = 5.0;
            4:       v = 11.0;
            5:       v = 21.0;
            default: v = (idx < 0) ? 0.02 : 42.0;
        endcase
        return v;
    endfunction

    // Physical quantities on the board can never be negative; a negative
    // setting is read as "none".
    function automatic real nonneg(input real x);
        return (x < 0.0) ? 0.0 : x;
    endfunction

    // Clamp a delay into [0, t_max].
    function automatic real clamp_tp(input real tp, input real t_max);
        real v;
        v = nonneg(tp);
        if (v > t_max) begin
            v = t_max;
        end
        return v;
    endfunction

    // Seconds -> delay-control units.
    function automatic real s_to_ticks(input real s);
        return s / S_PER_TICK;
    endfunction

endpackage

// File: rtl/tspcff_delay_model.sv
`timescale 1ns/100fs
// -----------------------------------------------------------------------------
// tspcff_delay_model
//
// Pure clk-to-q delay computation for the TSPC flip-flop board:
//   tp = T_INTRINSIC + K_SLOPE * clk_tt + R_DRIVE * load, clamped to [0, T_MAX].
// No state and no timing; the top samples tp_o at the moment of capture.
//
// Ports:
//   clk_tt_i  in  real  clock transition time, s (negative read as 0)
//   load_i    in  real  output load capacitance, F (negative read as 0)
//   tp_o      out real  clamped propagation delay, s
// -----------------------------------------------------------------------------
module tspcff_delay_model
    import tspcff_board_pkg::*;
#(
    parameter real T_INTRINSIC = T_INTRINSIC_DEF,
    parameter real K_SLOPE     = K_SLOPE_DEF,
    parameter real R_DRIVE     = R_DRIVE_DEF,
    parameter real T_MAX       = T_MAX_DEF
) (
    input  real clk_tt_i,
    input  real load_i,
    output real tp_o
);

    real slope_term;
    real load_term;

    always_comb begin
        slope_term = K_SLOPE * nonneg(clk_tt_i);
        load_term  = R_DRIVE * nonneg(load_i);
        tp_o       = clamp_tp(T_INTRINSIC + slope_term + load_term, T_MAX);
    end

endmodule

// File: rtl/tspcff_timing_board.sv
`timescale 1ns/100fs
// -----------------------------------------------------------------------------
// tspcff_timing_board
//
// Behavioural model of the characterisation breadboard around a TSPC D
// flip-flop. Turns logic stimulus plus analog settings (slopes, extra delays,
// load) into a timed flop output and reports the clk-to-q delay of each rising
// output transition. Intended for timing-characterisation benches only.
//
// Ports:
//   clk_logic           in  1    clock stimulus, flop captures on rising edge
//   rst_n               in  1    asynchronous active-low reset
//   din_logic           in  1    data stimulus
//   din_tt_val          in  real din transition time, s
//   clk_tt_val          in  real clk transition time, s
//   din_delay_val       in  real extra delay applied to din, s
//   clk_delay_val       in  real extra delay applied to clk, s
//   load_capacitor_val  in  real output load, F
//   dout_electrical     out 1    flop output, switches at its 50 % crossing
//   propagation         out real last rising clk-to-q delay, s
//
// Timing model:
//   * An input edge at time t reaches its 50 % point at t + delay + tt/2.
//   * At each clk 50 % rising point the flop samples the internal din level
//     that was valid strictly before that instant.
//   * The output follows the captured value tp later; tp comes from
//     tspcff_delay_model using the settings present at capture.
//   * Only one output update is ever outstanding: each capture (and reset)
//     retires whatever update was still pending.
// -----------------------------------------------------------------------------
module tspcff_timing_board
    import tspcff_board_pkg::*;
#(
    parameter real T_INTRINSIC = T_INTRINSIC_DEF,
    parameter real K_SLOPE     = K_SLOPE_DEF,
    parameter real R_DRIVE     = R_DRIVE_DEF,
    parameter real T_MAX       = T_MAX_DEF
) (
    input  logic clk_logic,
    input  logic rst_n,
    input  logic din_logic,
    input  real  din_tt_val,
    input  real  clk_tt_val,
    input  real  din_delay_val,
    input  real  clk_delay_val,
    input  real  load_capacitor_val,
    output logic dout_electrical,
    output real  propagation
);

    // -------------------------------------------------------------------------
    // Sanitised analog settings
    // -------------------------------------------------------------------------
    real din_tt_s;
    real clk_tt_s;
    real din_delay_s;
    real clk_delay_s;
    real load_s;
    real tp_s;

    always_comb begin
        din_tt_s    = nonneg(din_tt_val);
        clk_tt_s    = nonneg(clk_tt_val);
        din_delay_s = nonneg(din_delay_val);
        clk_delay_s = nonneg(clk_delay_val);
        load_s      = nonneg(load_capacitor_val);
    end

    tspcff_delay_model #(
        .T_INTRINSIC (T_INTRINSIC),
        .K_SLOPE     (K_SLOPE),
        .R_DRIVE     (R_DRIVE),
        .T_MAX       (T_MAX)
    ) u_delay_model (
        .clk_tt_i (clk_tt_s),
        .load_i   (load_s),
        .tp_o     (tp_s)
    );

    // -------------------------------------------------------------------------
    // Internal din: the level seen by the flop, updated at each din 50 % point.
    // Overlapping din changes each arrive after their own delay (transport).
    // -------------------------------------------------------------------------
    logic din_int_q;

    always begin
        @(din_logic);
        fork
            begin : din_path
                automatic logic lvl      = din_logic;
                automatic real  dly_tick = s_to_ticks(din_delay_s + din_tt_s / 2.0);
                #(dly_tick);
                // NOTE: non-blocking so a capture landing on the same instant
                // still reads the previous level -- coincident din and clk
                // 50 % points must capture the old value.
                din_int_q <= lvl;
            end
        join_none
    end

    // -------------------------------------------------------------------------
    // Capture, output scheduling and measurement.
    //
    // update_gen identifies the newest capture/reset. A pending output update
    // only lands if no later capture or reset has happened since it was
    // scheduled, which gives cancellation without killing processes.
    // -------------------------------------------------------------------------
    int unsigned update_gen;

    always begin
        @(posedge clk_logic or negedge rst_n);
        if (!rst_n) begin
            // NOTE: update_gen is bookkeeping read back within the same
            // process, so it is updated with blocking assignments; the
            // visible outputs always use non-blocking ones.
            update_gen      = update_gen + 1;
            dout_electrical <= 1'b0;
            propagation     <= 0.0;
        end else begin
            fork
                begin : capture_path
                    automatic real         cap_tick = s_to_ticks(clk_delay_s + clk_tt_s / 2.0);
                    automatic int unsigned my_gen;
                    automatic logic        cap_val;
                    automatic real         cap_tp;
                    #(cap_tick);
                    // Reset may have arrived between the edge and its 50 % point.
                    if (rst_n) begin
                        cap_val = din_int_q;
                        if ($isunknown(cap_val)) begin
                            cap_val = 1'bx;  // Z collapses to X on the output
                        end
                        cap_tp     = tp_s;
                        update_gen = update_gen + 1;
                        my_gen     = update_gen;
                        if (cap_val !== dout_electrical) begin
                            #(s_to_ticks(cap_tp));
                            if (my_gen == update_gen) begin
                                // Only clean rising transitions are measured;
                                // the delay from clk 50 % to dout 50 % is tp.
                                if (cap_val === 1'b1) begin
                                    propagation <= cap_tp;
                                end
                                dout_electrical <= cap_val;
                            end
                        end
                    end
                end
            join_none
        end
    end

endmodule

// File: tb/tb_tspcff_timing_board.sv
`timescale 1ns/100fs
// -----------------------------------------------------------------------------
// tb_tspcff_timing_board
//
// Directed plus randomized bench for the TSPC flop timing board. The clock
// rises every 20 ns; inputs change on the falling edge (10 ns ahead of the
// rise) and outputs are sampled on the next falling edge (10 ns after it).
// Expectations come from a small model of the board's rules in plain
// arithmetic: captured value, delay formula, expected output edge time.
// -----------------------------------------------------------------------------
module tb_tspcff_timing_board;
    import tspcff_board_pkg::*;

    logic clk_logic = 1'b0;
    logic rst_n     = 1'b1;
    logic din_logic = 1'b0;
    real  din_tt_val         = 0.0;
    real  clk_tt_val         = 0.0;
    real  din_delay_val      = 0.0;
    real  clk_delay_val      = 0.0;
    real  load_capacitor_val = 0.0;
    logic dout_electrical;
    real  propagation;

    tspcff_timing_board dut (
        .clk_logic          (clk_logic),
        .rst_n              (rst_n),
        .din_logic          (din_logic),
        .din_tt_val         (din_tt_val),
        .clk_tt_val         (clk_tt_val),
        .din_delay_val      (din_delay_val),
        .clk_delay_val      (clk_delay_val),
        .load_capacitor_val (load_capacitor_val),
        .dout_electrical    (dout_electrical),
        .propagation        (propagation)
    );

    always #10 clk_logic = ~clk_logic;

    // Output edge monitor: number of changes and time of the latest one (ns)
    int  dout_edges  = 0;
    real dout_edge_t = 0.0;
    always begin
        @(dout_electrical);
        dout_edges  = dout_edges + 1;
        dout_edge_t = $realtime;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic m_dout = 1'b0;
    real  m_prop = 0.0;
    real  last_offset = 0.0;  // ns from raw clk edge to dout edge, last step

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_real(input string tag, input real obs, input real exp, input real tol);
        n_total++;
        assert (((obs - exp) <= tol) && ((exp - obs) <= tol)) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %e expected %e", tag, obs, exp);
        end
    endtask

    function automatic real pos(input real x);
        return (x < 0.0) ? 0.0 : x;
    endfunction

    // Delay formula in seconds: 40 ps + 0.25*slope + 5 kohm*load, max 5 ns
    function automatic real model_tp(input real ctt, input real ld);
        real tp;
        tp = 40.0e-12 + 0.25 * pos(ctt) + 5.0e3 * pos(ld);
        if (tp > 5.0e-9) tp = 5.0e-9;
        return pos(tp);
    endfunction

    // One clock period: apply settings, let one rise happen, check outputs.
    task automatic step(input string tag, input logic d, input real ctt, input real cdel,
                        input real ld, input real dtt, input real ddel);
        logic cap;
        real  tp;
        real  t_edge;
        real  t_exp;
        int   edges0;
        bit   moves;
        din_logic          = d;
        clk_tt_val         = ctt;
        clk_delay_val      = cdel;
        load_capacitor_val = ld;
        din_tt_val         = dtt;
        din_delay_val      = ddel;
        @(posedge clk_logic);
        t_edge = $realtime;
        edges0 = dout_edges;
        @(negedge clk_logic);
        cap   = $isunknown(d) ? 1'bx : d;
        tp    = model_tp(ctt, ld);
        moves = (cap !== m_dout);
        t_exp = t_edge + (pos(cdel) + pos(ctt) / 2.0 + tp) * 1.0e9;
        if (moves) begin
            if (cap === 1'b1) m_prop = tp;
            m_dout = cap;
        end
        check_bit({tag, ".dout"}, dout_electrical, m_dout);
        check_real({tag, ".prop"}, propagation, m_prop, 1.0e-16);
        check_int({tag, ".edges"}, dout_edges, edges0 + (moves ? 1 : 0));
        if (moves) begin
            check_real({tag, ".t_out"}, dout_edge_t, t_exp, 3.0e-4);
            last_offset = dout_edge_t - t_edge;
        end
    endtask

    initial begin
        int   edges0;
        real  offset_nodelay;
        logic rd;
        real  r_ctt;
        real  r_ld;
        real  r_cdel;
        real  r_dtt;
        real  r_ddel;

        // Reset held with the clock running and din = 1
        #1;
        rst_n              = 1'b0;
        din_logic          = 1'b1;
        clk_tt_val         = 0.1e-9;
        load_capacitor_val = 5.0e-15;
        repeat (3) begin
            @(negedge clk_logic);
            check_bit("rst.dout", dout_electrical, 1'b0);
            check_real("rst.prop", propagation, 0.0, 0.0);
        end
        m_dout = 1'b0;
        m_prop = 0.0;

        // Release; first rise with din = 1 must propagate (tp = 90 ps)
        rst_n = 1'b1;
        step("release", 1'b1, 0.1e-9, 0.0, 5.0e-15, 0.05e-9, 0.5e-9);
        offset_nodelay = last_offset;
        step("fall_a", 1'b0, 0.1e-9, 0.0, 5.0e-15, 0.0, 0.0);

        // Min corner: 40.35 ps
        step("min_corner", 1'b1, 1.0e-12, 0.0, 0.02e-15, 0.0, 0.0);
        check_real("min_corner.value", propagation, 40.35e-12, 1.0e-16);
        step("fall_b", 1'b0, 1.0e-12, 0.0, 0.02e-15, 0.0, 0.0);

        // Max corner: 300 ps
        step("max_corner", 1'b1, 200.0e-12, 0.0, 42.0e-15, 0.0, 0.0);
        check_real("max_corner.value", propagation, 300.0e-12, 1.0e-16);
        step("fall_c", 1'b0, 200.0e-12, 0.0, 42.0e-15, 0.0, 0.0);

        // Clock delay 1 ns: 90 ps and an output edge 1 ns later than before
        step("clk_delay", 1'b1, 100.0e-12, 1.0e-9, 5.0e-15, 0.0, 0.0);
        check_real("clk_delay.value", propagation, 90.0e-12, 1.0e-16);
        check_real("clk_delay.shift", last_offset - offset_nodelay, 1.0, 3.0e-4);

        // Same value again: no transition, propagation unchanged
        step("hold_one", 1'b1, 30.0e-12, 0.0, 1.25e-15, 0.0, 0.0);

        // Randomized sweep over the characterisation grids
        for (int i = 0; i < 12; i++) begin
            rd     = 1'($urandom_range(0, 1));
            r_ctt  = slope_grid_ns(int'($urandom_range(0, GRID_POINTS - 1))) * 1.0e-9;
            r_ld   = load_grid_ff(int'($urandom_range(0, GRID_POINTS - 1))) * 1.0e-15;
            r_cdel = real'($urandom_range(0, 2000)) * 1.0e-12;
            r_dtt  = real'($urandom_range(0, 200)) * 1.0e-12;
            r_ddel = real'($urandom_range(0, 3000)) * 1.0e-12;
            step($sformatf("rnd%0d", i), rd, r_ctt, r_cdel, r_ld, r_dtt, r_ddel);
        end

        // Negative settings read as zero (tp = 40 ps, no extra delay)
        step("neg_lo", 1'b0, -50.0e-12, -1.0e-9, -3.0e-15, -1.0e-12, -2.0e-9);
        step("neg_hi", 1'b1, -50.0e-12, -1.0e-9, -3.0e-15, -1.0e-12, -2.0e-9);

        // Unknown data: output goes X, propagation kept
        step("x_in", 1'bx, 70.0e-12, 0.0, 2.5e-15, 0.0, 0.0);
        step("x_clear", 1'b0, 70.0e-12, 0.0, 2.5e-15, 0.0, 0.0);

        // Reset 10 ps after a capture with tp = 300 ps pending
        din_logic          = 1'b1;
        clk_tt_val         = 200.0e-12;
        clk_delay_val      = 0.0;
        load_capacitor_val = 42.0e-15;
        din_tt_val         = 0.0;
        din_delay_val      = 0.0;
        @(posedge clk_logic);
        edges0 = dout_edges;
        #0.11;
        rst_n = 1'b0;
        @(negedge clk_logic);
        check_bit("mid_rst.dout", dout_electrical, 1'b0);
        check_real("mid_rst.prop", propagation, 0.0, 0.0);
        check_int("mid_rst.edges", dout_edges, edges0);
        @(negedge clk_logic);
        check_bit("mid_rst.dout_late", dout_electrical, 1'b0);
        check_int("mid_rst.edges_late", dout_edges, edges0);
        m_dout = 1'b0;
        m_prop = 0.0;
        rst_n  = 1'b1;
        step("after_rst", 1'b1, 200.0e-12, 0.0, 42.0e-15, 0.0, 0.0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
